// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB slave with word-organised memory, wait states, ERROR response
// Optional write-protect window enabled by defining AHB_MEM_SLAVE_WP_EN.
module ahb_mem_slave #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] WP_BASE     = 32'h0000_0000,
  parameter logic [31:0] WP_LIMIT    = 32'h0000_003F
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH) << 2;
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [3:0]     be_q, be_d;
  logic           write_q, write_d;
  logic [31:0]    hrdata_q, hrdata_d;

  logic [31:0]    mem_q [DEPTH];

  logic           accept;
  logic           addr_err;
  logic           size_err;
  logic           align_err;
  logic           wp_err;
  logic           req_err;
  logic [AW-1:0]  acc_idx;
  logic [3:0]     acc_be;
  logic           wr_commit;
  logic           rd_load;
  logic [AW-1:0]  rd_idx;
  logic [31:0]    merged;

`ifdef AHB_MEM_SLAVE_WP_EN
  logic unused_sig;
  assign unused_sig = ^{HBURST, HTRANS[0]};
`else
  logic unused_sig;
  assign unused_sig = ^{HBURST, HTRANS[0], WP_BASE, WP_LIMIT};
`endif

  // Address-phase decode: accept qualification, error classification, lane enables
  always_comb begin
    accept    = HSEL && HREADY && HTRANS[1] && (state_q == S_IDLE || state_q == S_DATA);
    addr_err  = (HADDR >= MEM_BYTES);
    size_err  = (HSIZE > 3'd2);
    align_err = ((HSIZE == 3'd1) && HADDR[0]) || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`ifdef AHB_MEM_SLAVE_WP_EN
    wp_err    = HWRITE && (HADDR >= WP_BASE) && (HADDR <= WP_LIMIT);
`else
    wp_err    = 1'b0;
`endif
    req_err   = addr_err || size_err || align_err || wp_err;
    acc_idx   = HADDR[AW+1:2];
    case (HSIZE)
      3'd0:    acc_be = 4'b0001 << HADDR[1:0];
      3'd1:    acc_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: acc_be = 4'b1111;
    endcase
  end

  // Write commit at the end of DATA, plus the merged word used for same-edge read bypass
  always_comb begin
    wr_commit = (state_q == S_DATA) && write_q;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be_q[i] ? HWDATA[8*i +: 8] : mem_q[idx_q][8*i +: 8];
    end
  end

  // Next-state logic, captured control and read-load request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    rd_load = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          idx_d   = acc_idx;
          be_d    = acc_be;
          write_d = HWRITE;
          if (req_err) begin
            state_d = S_ERR1;
            write_d = 1'b0;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_DATA;
            rd_load = !HWRITE;
            rd_idx  = acc_idx;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          rd_load = !write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data register: loads on entry to DATA, bypassing a same-edge write to the same word
  always_comb begin
    hrdata_d = hrdata_q;
    if (rd_load) begin
      if (wr_commit && (rd_idx == idx_q)) begin
        hrdata_d = merged;
      end else begin
        hrdata_d = mem_q[rd_idx];
      end
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      be_q     <= 4'd0;
      write_q  <= 1'b0;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Memory byte-lane writes; contents survive reset, but reset blocks a pending commit
  always_ff @(posedge HCLK) begin
    if (HRESETn && wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Response outputs decoded from state
  always_comb begin
    HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    HRDATA    = hrdata_q;
  end

endmodule
